// File: rtl/sensor_mux_arbiter_if.sv
// Handshake bundle between the four sensor front-ends and the shared-mux arbiter.
// The master side raises requests; the slave side (the arbiter) returns grant and status.
interface sensor_mux_arbiter_if;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] sel;
   logic       busy;
   logic       timeout;
   logic [3:0] lockout;

   modport master (
      output req,
      input  gnt, sel, busy, timeout, lockout
   );

   modport slave (
      input  req,
      output gnt, sel, busy, timeout, lockout
   );
endinterface

// File: rtl/sensor_mux_arbiter.sv
// Round-robin arbiter for the 4-to-1 sensor mux with a bounded hold window,
// a one-cycle gap between grants, and lockout of channels that overrun the window.
module sensor_mux_arbiter #(
   parameter int HOLD_CYCLES = 8,
   parameter int CNT_W       = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   sensor_mux_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_CYCLES - 1);

   state_t           state_q, state_d;
   logic [3:0]       gnt_q, gnt_d;
   logic [3:0]       lockout_q, lockout_d;
   logic [1:0]       sel_q, sel_d;
   logic [1:0]       last_q, last_d;
   logic             busy_q, busy_d;
   logic             timeout_q, timeout_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [3:0]       elig;
   logic [1:0]       winner;
   logic [1:0]       cand;
   logic             found;

   // Search starts one past the last granted channel, wrapping through all four.
   always_comb begin
      elig   = bus.req & ~lockout_q;
      winner = last_q;
      cand   = last_q;
      found  = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         cand = last_q + 2'(k);
         if (!found && elig[cand]) begin
            winner = cand;
            found  = 1'b1;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      sel_d     = sel_q;
      last_d    = last_q;
      busy_d    = busy_q;
      timeout_d = 1'b0;
      cnt_d     = cnt_q;
      lockout_d = lockout_q & bus.req;
      case (state_q)
         IDLE, GAP: begin
            if (found) begin
               state_d = GRANT;
               gnt_d   = 4'b0001 << winner;
               sel_d   = winner;
               busy_d  = 1'b1;
               cnt_d   = '0;
            end else begin
               state_d = IDLE;
               gnt_d   = '0;
               busy_d  = 1'b0;
            end
         end
         GRANT: begin
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
            // A dropped request outranks the hold limit when both land together.
            if (!bus.req[sel_q]) begin
               state_d = GAP;
               gnt_d   = '0;
               busy_d  = 1'b0;
               last_d  = sel_q;
            end else if (cnt_q == CNT_MAX) begin
               state_d           = GAP;
               gnt_d             = '0;
               busy_d            = 1'b0;
               last_d            = sel_q;
               timeout_d         = 1'b1;
               lockout_d[sel_q]  = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         gnt_q     <= '0;
         sel_q     <= '0;
         last_q    <= 2'd3;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
         cnt_q     <= '0;
         lockout_q <= '0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         sel_q     <= sel_d;
         last_q    <= last_d;
         busy_q    <= busy_d;
         timeout_q <= timeout_d;
         cnt_q     <= cnt_d;
         lockout_q <= lockout_d;
      end
   end

   assign bus.gnt     = gnt_q;
   assign bus.sel     = sel_q;
   assign bus.busy    = busy_q;
   assign bus.timeout = timeout_q;
   assign bus.lockout = lockout_q;

endmodule

// File: tb/tb_sensor_mux_arbiter.sv
// Bench for sensor_mux_arbiter: directed scenarios plus random requests, each cycle
// compared against a channel-ownership model of the arbitration rules.
module tb_sensor_mux_arbiter;

   localparam int HOLD = 8;

   logic clk;
   logic rst_n;
   sensor_mux_arbiter_if bus();

   sensor_mux_arbiter #(.HOLD_CYCLES(HOLD), .CNT_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int n_cycle  = 0;

   // Model: who owns the mux (-1 = nobody), how many cycles it has held it so far.
   int       m_owner;
   int       m_elapsed;
   int       m_last;
   int       m_sel;
   bit [3:0] m_lock;
   bit       m_tmo;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, n_cycle, got, exp);
      end
   endtask

   function automatic void model_reset();
      m_owner   = -1;
      m_elapsed = 0;
      m_last    = 3;
      m_sel     = 0;
      m_lock    = '0;
      m_tmo     = 1'b0;
   endfunction

   function automatic void model_step(input logic [3:0] r);
      bit [3:0] elig;
      bit [3:0] new_lock;
      int       w;
      elig     = r & ~m_lock;
      new_lock = m_lock & r;
      m_tmo    = 1'b0;
      if (m_owner >= 0) begin
         if (!r[m_owner]) begin
            m_last  = m_owner;
            m_owner = -1;
         end else if (m_elapsed == HOLD) begin
            m_last           = m_owner;
            new_lock[m_owner] = 1'b1;
            m_tmo            = 1'b1;
            m_owner          = -1;
         end else begin
            m_elapsed++;
         end
      end else begin
         w = -1;
         for (int k = 1; k <= 4; k++)
            if (w < 0 && elig[(m_last + k) % 4]) w = (m_last + k) % 4;
         if (w >= 0) begin
            m_owner   = w;
            m_sel     = w;
            m_elapsed = 1;
            $display("cycle %0d: grant ch%0d (req=%b lockout=%b)", n_cycle, w, r, m_lock);
         end
      end
      m_lock = new_lock;
   endfunction

   task automatic check_outputs();
      logic [3:0] exp_gnt;
      exp_gnt = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
      check_val("gnt",     32'(bus.gnt),     32'(exp_gnt));
      check_val("busy",    32'(bus.busy),    32'(m_owner >= 0));
      check_val("sel",     32'(bus.sel),     32'(m_sel));
      check_val("timeout", 32'(bus.timeout), 32'(m_tmo));
      check_val("lockout", 32'(bus.lockout), 32'(m_lock));
      check_val("gnt_onehot0", 32'($onehot0(bus.gnt)), 32'd1);
   endtask

   // Called at a falling edge: drive req, advance one rising edge, check at the next fall.
   task automatic step(input logic [3:0] r);
      bus.req = r;
      @(posedge clk);
      n_cycle++;
      model_step(r);
      @(negedge clk);
      check_outputs();
   endtask

   initial begin
      logic [3:0] r;
      rst_n   = 1'b0;
      bus.req = 4'b0000;
      model_reset();
      repeat (2) @(negedge clk);
      check_outputs();
      rst_n = 1'b1;

      // Single requester, normal release after three cycles.
      repeat (3) step(4'b0001);
      repeat (3) step(4'b0000);

      // All channels requesting; a locked channel drops req for one cycle to clear it.
      for (int i = 0; i < 80; i++) step(4'b1111 & ~4'(m_lock));
      repeat (3) step(4'b0000);

      // Channel 2 overruns alone, stays locked, then clears and is granted again.
      repeat (14) step(4'b0100);
      step(4'b0000);
      repeat (3) step(4'b0100);
      repeat (3) step(4'b0000);

      // Fairness from last=1 with req=1011: expect 3, 0, 1.
      repeat (2) step(4'b0010);
      repeat (2) step(4'b0000);
      for (int i = 0; i < 16; i++) begin
         r = 4'b1011;
         if (m_owner >= 0 && m_elapsed >= 2) r[m_owner] = 1'b0;
         step(r);
      end
      repeat (2) step(4'b0000);

      // Request drops on the very cycle the hold limit is reached.
      for (int i = 0; i < 12; i++) begin
         r = 4'b0001;
         if (m_owner == 0 && m_elapsed == HOLD) r = 4'b0000;
         step(r);
      end
      repeat (2) step(4'b0000);

      // Random traffic with sticky requests.
      r = 4'b0000;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
         step(r);
      end
      repeat (3) step(4'b0000);

      // Asynchronous reset in the middle of a grant with a channel locked.
      repeat (11) step(4'b0100);
      repeat (2) step(4'b0101);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs();
      @(negedge clk);
      check_outputs();
      rst_n = 1'b1;
      repeat (3) step(4'b1010);
      repeat (3) step(4'b0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
